// File: rtl/mby_gmm_pkg.sv
// mby_gmm_pkg -- shared types and defaults for the GMM ring repeater.
//   mby_starve_e        : per-channel injection starvation state.
//   MBY_RING_DEST_BCAST : broadcast destination (all ones, sliced to DEST_W).
//   MBY_*_DEF           : default parameter values for the ring repeater.
package mby_gmm_pkg;

  localparam int unsigned MBY_NUM_CH_DEF     = 4;
  localparam int unsigned MBY_DATA_W_DEF     = 64;
  localparam int unsigned MBY_DEPTH_DEF      = 2;
  localparam int unsigned MBY_DEST_W_DEF     = 4;
  localparam int unsigned MBY_DEST_LSB_DEF   = 0;
  localparam int unsigned MBY_REMOVE_TAP_DEF = 1;
  localparam int unsigned MBY_STARVE_LIM_DEF = 15;
  localparam int unsigned MBY_CNT_W_DEF      = 16;

  // Held at 32 bits so any DEST_W up to 32 can slice its own width.
  localparam logic [31:0] MBY_RING_DEST_BCAST = '1;

  typedef enum logic [1:0] {
    STV_IDLE    = 2'd0,
    STV_WAIT    = 2'd1,
    STV_STARVED = 2'd2
  } mby_starve_e;

endpackage

// File: rtl/mby_gmm_ring_ch.sv
// mby_gmm_ring_ch -- one ring channel of the GMM ring repeater.
//   cclk, reset_n            : clock, asynchronous active-low reset
//   local_id                 : static destination strap
//   ring_in_vld/ring_in_data : slot arriving at stage 0
//   ring_out_vld/_data       : slot leaving the last stage
//   tap_vld/tap_data         : slot delivered to the local agent
//   inj_req/inj_data/inj_gnt : local injection handshake (grant is combinational)
//   inj_starve               : injection has waited STARVE_LIM ungranted cycles
//   cnt_clr, cnt_pass/tap/inj: saturating statistics
// Counters are built only when MBY_GMM_RING_CNT_EN is defined; otherwise the
// counter outputs are tied to zero.
module mby_gmm_ring_ch
  import mby_gmm_pkg::*;
#(
  parameter int unsigned DATA_W        = MBY_DATA_W_DEF,
  parameter int unsigned DEPTH         = MBY_DEPTH_DEF,
  parameter int unsigned DEST_W        = MBY_DEST_W_DEF,
  parameter int unsigned DEST_LSB      = MBY_DEST_LSB_DEF,
  parameter int unsigned REMOVE_ON_TAP = MBY_REMOVE_TAP_DEF,
  parameter int unsigned STARVE_LIM    = MBY_STARVE_LIM_DEF,
  parameter int unsigned CNT_W         = MBY_CNT_W_DEF
) (
  input  logic              cclk,
  input  logic              reset_n,
  input  logic [DEST_W-1:0] local_id,
  input  logic              ring_in_vld,
  input  logic [DATA_W-1:0] ring_in_data,
  output logic              ring_out_vld,
  output logic [DATA_W-1:0] ring_out_data,
  output logic              tap_vld,
  output logic [DATA_W-1:0] tap_data,
  input  logic              inj_req,
  input  logic [DATA_W-1:0] inj_data,
  output logic              inj_gnt,
  output logic              inj_starve,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_pass,
  output logic [CNT_W-1:0]  cnt_tap,
  output logic [CNT_W-1:0]  cnt_inj
);

  localparam int unsigned WC_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  logic [DEST_W-1:0]            dest;
  logic                         hit_local;
  logic                         hit_bcast;
  logic                         remove;
  logic                         slot_free;
  logic                         s0_vld;
  logic [DATA_W-1:0]            s0_data;
  logic [DEPTH-1:0]             stg_vld;
  logic [DEPTH-1:0][DATA_W-1:0] stg_data;
  mby_starve_e                  st;
  logic [WC_W-1:0]              wait_cnt;
  logic [WC_W-1:0]              wait_inc;

  // Slot decode and stage-0 selection.
  always_comb begin
    dest      = ring_in_data[DEST_LSB +: DEST_W];
    hit_local = ring_in_vld && (dest == local_id);
    hit_bcast = ring_in_vld && (dest == MBY_RING_DEST_BCAST[DEST_W-1:0]);
    // Broadcast wins even when local_id is itself all ones.
    remove    = hit_local && !hit_bcast && (REMOVE_ON_TAP != 0);
    slot_free = !ring_in_vld || remove;
    // Gated by reset so no grant is seen while the channel is held in reset.
    inj_gnt   = inj_req && slot_free && reset_n;
    s0_vld    = inj_gnt || (ring_in_vld && !remove);
    s0_data   = inj_gnt ? inj_data : ring_in_data;
  end

  always_ff @(posedge cclk or negedge reset_n) begin
    if (!reset_n) begin
      stg_vld  <= '0;
      stg_data <= '0;
    end else begin
      stg_vld[0]  <= s0_vld;
      stg_data[0] <= s0_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stg_vld[i]  <= stg_vld[i-1];
        stg_data[i] <= stg_data[i-1];
      end
    end
  end

  assign ring_out_vld  = stg_vld[DEPTH-1];
  assign ring_out_data = stg_data[DEPTH-1];

  // Tap looks only at the incoming slot, so this instance never taps its own injections.
  always_ff @(posedge cclk or negedge reset_n) begin
    if (!reset_n) begin
      tap_vld  <= 1'b0;
      tap_data <= '0;
    end else begin
      tap_vld  <= hit_local || hit_bcast;
      tap_data <= ring_in_data;
    end
  end

  // Starvation tracking: the entering cycle counts as the first ungranted one.
  assign wait_inc = wait_cnt + WC_W'(1);

  always_ff @(posedge cclk or negedge reset_n) begin
    if (!reset_n) begin
      st       <= STV_IDLE;
      wait_cnt <= '0;
    end else if (inj_gnt || !inj_req) begin
      st       <= STV_IDLE;
      wait_cnt <= '0;
    end else begin
      case (st)
        STV_IDLE, STV_WAIT: begin
          wait_cnt <= wait_inc;
          st       <= (wait_inc >= WC_W'(STARVE_LIM)) ? STV_STARVED : STV_WAIT;
        end
        STV_STARVED: st <= STV_STARVED;
        default: begin
          st       <= STV_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign inj_starve = (st == STV_STARVED);

`ifdef MBY_GMM_RING_CNT_EN
  always_ff @(posedge cclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_pass <= '0;
      cnt_tap  <= '0;
      cnt_inj  <= '0;
    end else if (cnt_clr) begin
      cnt_pass <= '0;
      cnt_tap  <= '0;
      cnt_inj  <= '0;
    end else begin
      if (ring_out_vld && (cnt_pass != '1)) cnt_pass <= cnt_pass + CNT_W'(1);
      if (tap_vld      && (cnt_tap  != '1)) cnt_tap  <= cnt_tap  + CNT_W'(1);
      if (inj_gnt      && (cnt_inj  != '1)) cnt_inj  <= cnt_inj  + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt_pass = '0;
  assign cnt_tap  = '0;
  assign cnt_inj  = '0;
`endif

endmodule

// File: rtl/mby_gmm_ring_rptr.sv
// mby_gmm_ring_rptr -- GMM ring repeater: NUM_CH independent ring channels,
// each a DEPTH-stage pipeline with destination tap, local injection,
// starvation flag and statistics (mby_gmm_ring_ch per channel).
//   cclk, reset_n                 : clock, asynchronous active-low reset
//   local_id                      : static destination strap
//   ring_in_*/ring_out_*          : ring slots in/out, channel c at [c*DATA_W +: DATA_W]
//   tap_vld/tap_data              : slots delivered to the local agent
//   inj_req/inj_data/inj_gnt      : local injection handshake
//   inj_starve                    : per-channel starvation flag
//   cnt_clr, cnt_pass/tap/inj     : statistics, channel c at [c*CNT_W +: CNT_W]
// Statistics are built only with MBY_GMM_RING_CNT_EN defined; otherwise zero.
module mby_gmm_ring_rptr
  import mby_gmm_pkg::*;
#(
  parameter int unsigned NUM_CH        = MBY_NUM_CH_DEF,
  parameter int unsigned DATA_W        = MBY_DATA_W_DEF,
  parameter int unsigned DEPTH         = MBY_DEPTH_DEF,
  parameter int unsigned DEST_W        = MBY_DEST_W_DEF,
  parameter int unsigned DEST_LSB      = MBY_DEST_LSB_DEF,
  parameter int unsigned REMOVE_ON_TAP = MBY_REMOVE_TAP_DEF,
  parameter int unsigned STARVE_LIM    = MBY_STARVE_LIM_DEF,
  parameter int unsigned CNT_W         = MBY_CNT_W_DEF
) (
  input  logic                     cclk,
  input  logic                     reset_n,
  input  logic [DEST_W-1:0]        local_id,
  input  logic [NUM_CH-1:0]        ring_in_vld,
  input  logic [NUM_CH*DATA_W-1:0] ring_in_data,
  output logic [NUM_CH-1:0]        ring_out_vld,
  output logic [NUM_CH*DATA_W-1:0] ring_out_data,
  output logic [NUM_CH-1:0]        tap_vld,
  output logic [NUM_CH*DATA_W-1:0] tap_data,
  input  logic [NUM_CH-1:0]        inj_req,
  input  logic [NUM_CH*DATA_W-1:0] inj_data,
  output logic [NUM_CH-1:0]        inj_gnt,
  output logic [NUM_CH-1:0]        inj_starve,
  input  logic                     cnt_clr,
  output logic [NUM_CH*CNT_W-1:0]  cnt_pass,
  output logic [NUM_CH*CNT_W-1:0]  cnt_tap,
  output logic [NUM_CH*CNT_W-1:0]  cnt_inj
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mby_gmm_ring_ch #(
      .DATA_W       (DATA_W),
      .DEPTH        (DEPTH),
      .DEST_W       (DEST_W),
      .DEST_LSB     (DEST_LSB),
      .REMOVE_ON_TAP(REMOVE_ON_TAP),
      .STARVE_LIM   (STARVE_LIM),
      .CNT_W        (CNT_W)
    ) u_ch (
      .cclk         (cclk),
      .reset_n      (reset_n),
      .local_id     (local_id),
      .ring_in_vld  (ring_in_vld[g]),
      .ring_in_data (ring_in_data[g*DATA_W +: DATA_W]),
      .ring_out_vld (ring_out_vld[g]),
      .ring_out_data(ring_out_data[g*DATA_W +: DATA_W]),
      .tap_vld      (tap_vld[g]),
      .tap_data     (tap_data[g*DATA_W +: DATA_W]),
      .inj_req      (inj_req[g]),
      .inj_data     (inj_data[g*DATA_W +: DATA_W]),
      .inj_gnt      (inj_gnt[g]),
      .inj_starve   (inj_starve[g]),
      .cnt_clr      (cnt_clr),
      .cnt_pass     (cnt_pass[g*CNT_W +: CNT_W]),
      .cnt_tap      (cnt_tap[g*CNT_W +: CNT_W]),
      .cnt_inj      (cnt_inj[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_mby_gmm_ring_rptr.sv
// tb_mby_gmm_ring_rptr -- scoreboard bench for mby_gmm_ring_rptr (defaults,
// local_id=3). A second instance with REMOVE_ON_TAP=0 shares the inputs.
// Counter expectations are zero unless MBY_GMM_RING_CNT_EN is defined.
module tb_mby_gmm_ring_rptr;

  localparam int unsigned NC = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 16;
`ifdef MBY_GMM_RING_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             cclk = 1'b0;
  logic             reset_n = 1'b1;
  logic [3:0]       local_id = 4'd3;
  logic [NC-1:0]    ring_in_vld = '0;
  logic [NC*DW-1:0] ring_in_data = '0;
  logic [NC-1:0]    inj_req = '0;
  logic [NC*DW-1:0] inj_data = '0;
  logic             cnt_clr = 1'b0;

  logic [NC-1:0]    ring_out_vld, tap_vld, inj_gnt, inj_starve;
  logic [NC*DW-1:0] ring_out_data, tap_data;
  logic [NC*CW-1:0] cnt_pass, cnt_tap, cnt_inj;

  logic [NC-1:0]    ring_out_vld_c, tap_vld_c, inj_gnt_c, inj_starve_c;
  logic [NC*DW-1:0] ring_out_data_c, tap_data_c;
  logic [NC*CW-1:0] cnt_pass_c, cnt_tap_c, cnt_inj_c;

  always #5 cclk = ~cclk;

  mby_gmm_ring_rptr dut (
    .cclk(cclk), .reset_n(reset_n), .local_id(local_id),
    .ring_in_vld(ring_in_vld), .ring_in_data(ring_in_data),
    .ring_out_vld(ring_out_vld), .ring_out_data(ring_out_data),
    .tap_vld(tap_vld), .tap_data(tap_data),
    .inj_req(inj_req), .inj_data(inj_data), .inj_gnt(inj_gnt),
    .inj_starve(inj_starve), .cnt_clr(cnt_clr),
    .cnt_pass(cnt_pass), .cnt_tap(cnt_tap), .cnt_inj(cnt_inj)
  );

  mby_gmm_ring_rptr #(.REMOVE_ON_TAP(0)) dut_copy (
    .cclk(cclk), .reset_n(reset_n), .local_id(local_id),
    .ring_in_vld(ring_in_vld), .ring_in_data(ring_in_data),
    .ring_out_vld(ring_out_vld_c), .ring_out_data(ring_out_data_c),
    .tap_vld(tap_vld_c), .tap_data(tap_data_c),
    .inj_req(inj_req), .inj_data(inj_data), .inj_gnt(inj_gnt_c),
    .inj_starve(inj_starve_c), .cnt_clr(cnt_clr),
    .cnt_pass(cnt_pass_c), .cnt_tap(cnt_tap_c), .cnt_inj(cnt_inj_c)
  );

  int unsigned cyc = 0;
  always @(posedge cclk) cyc <= cyc + 1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef enum int {
    K_OUT_VLD0, K_OUT_DATA0, K_OUT_VLD1, K_TAP_VLD0, K_TAP_DATA0, K_GNT0,
    K_STARVE0, K_OUT_VLD0_COPY, K_CNT_PASS0, K_CNT_TAP0, K_CNT_INJ0
  } kind_e;

  typedef struct {
    int unsigned due;
    kind_e       kind;
    logic [63:0] exp;
  } sb_t;

  sb_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic expect_at(input int unsigned due, input kind_e k, input logic [63:0] e);
    sb.push_back('{due: due, kind: k, exp: e});
  endtask

  function automatic logic [63:0] cexp(input logic [63:0] v);
    return CNT_ON ? v : 64'd0;
  endfunction

  function automatic logic [63:0] observe(input kind_e k);
    case (k)
      K_OUT_VLD0:      return 64'(ring_out_vld[0]);
      K_OUT_DATA0:     return ring_out_data[63:0];
      K_OUT_VLD1:      return 64'(ring_out_vld[1]);
      K_TAP_VLD0:      return 64'(tap_vld[0]);
      K_TAP_DATA0:     return tap_data[63:0];
      K_GNT0:          return 64'(inj_gnt[0]);
      K_STARVE0:       return 64'(inj_starve[0]);
      K_OUT_VLD0_COPY: return 64'(ring_out_vld_c[0]);
      K_CNT_PASS0:     return 64'(cnt_pass[15:0]);
      K_CNT_TAP0:      return 64'(cnt_tap[15:0]);
      K_CNT_INJ0:      return 64'(cnt_inj[15:0]);
      default:         return '1;
    endcase
  endfunction

  // Scoreboard: compare every entry whose due cycle is the current one.
  always @(negedge cclk) begin
    int unsigned i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        chk(sb[i].kind.name(), observe(sb[i].kind), sb[i].exp);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic goto(input int unsigned c);
    while (cyc < c) begin
      @(posedge cclk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    ring_in_vld  = '0;
    ring_in_data = '0;
    inj_req      = '0;
    inj_data     = '0;
    cnt_clr      = 1'b0;
  endtask

  task automatic drive0(input logic v, input logic [63:0] d);
    ring_in_vld[0]     = v;
    ring_in_data[63:0] = d;
  endtask

  task automatic do_reset(output int unsigned base);
    @(posedge cclk);
    #1;
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge cclk);
    #1;
    reset_n = 1'b1;
    base = cyc;
  endtask

  localparam logic [63:0] D_PASS  = 64'h0000_0000_0000_00A5; // dest 5
  localparam logic [63:0] D_MATCH = 64'h0000_0000_0000_00C3; // dest 3
  localparam logic [63:0] D_BCAST = 64'h0000_0000_0000_00BF; // dest F
  localparam logic [63:0] D_INJ   = 64'h1234_5678_9ABC_DEF7;
  localparam logic [63:0] D_INJ2  = 64'h5555_0000_0000_00E7;

  initial begin
    int unsigned b;
    int unsigned c;

    // Reset state: grant must stay low even though the slot is empty.
    #1 reset_n = 1'b0;
    inj_req = '1;
    #2;
    chk("rst_out_vld",   64'(ring_out_vld), 64'd0);
    chk("rst_tap_vld",   64'(tap_vld), 64'd0);
    chk("rst_inj_gnt",   64'(inj_gnt), 64'd0);
    chk("rst_starve",    64'(inj_starve), 64'd0);
    chk("rst_out_data",  ring_out_data[63:0], 64'd0);
    chk("rst_cnt_pass",  64'(cnt_pass[15:0]), 64'd0);
    ring_in_vld = '1;
    ring_in_data = {4{D_PASS}};
    repeat (3) @(posedge cclk);
    #1;
    chk("rst_hold_out_vld", 64'(ring_out_vld), 64'd0);
    chk("rst_hold_tap_data", tap_data[63:0], 64'd0);

    // Passthrough.
    do_reset(b);
    goto(b + 10); drive0(1'b1, D_PASS);
    expect_at(b + 10, K_GNT0, 64'd0);
    expect_at(b + 11, K_TAP_VLD0, 64'd0);
    expect_at(b + 11, K_OUT_VLD0, 64'd0);
    expect_at(b + 12, K_OUT_VLD0, 64'd1);
    expect_at(b + 12, K_OUT_DATA0, D_PASS);
    expect_at(b + 12, K_OUT_VLD1, 64'd0);
    expect_at(b + 13, K_CNT_PASS0, cexp(64'd1));
    goto(b + 11); drive0(1'b0, 64'd0);
    expect_at(b + 13, K_OUT_VLD0, 64'd0);
    goto(b + 16);

    // Tap-remove, and copy-forward on the REMOVE_ON_TAP=0 instance.
    do_reset(b);
    goto(b + 10); drive0(1'b1, D_MATCH);
    expect_at(b + 11, K_TAP_VLD0, 64'd1);
    expect_at(b + 11, K_TAP_DATA0, D_MATCH);
    expect_at(b + 12, K_OUT_VLD0, 64'd0);
    expect_at(b + 12, K_OUT_VLD0_COPY, 64'd1);
    expect_at(b + 12, K_TAP_VLD0, 64'd0);
    goto(b + 11); drive0(1'b0, 64'd0);
    goto(b + 16);

    // Broadcast: tapped and forwarded.
    do_reset(b);
    goto(b + 10); drive0(1'b1, D_BCAST);
    expect_at(b + 11, K_TAP_VLD0, 64'd1);
    expect_at(b + 11, K_TAP_DATA0, D_BCAST);
    expect_at(b + 12, K_OUT_VLD0, 64'd1);
    expect_at(b + 12, K_OUT_DATA0, D_BCAST);
    expect_at(b + 12, K_CNT_TAP0, cexp(64'd1));
    expect_at(b + 13, K_CNT_PASS0, cexp(64'd1));
    goto(b + 11); drive0(1'b0, 64'd0);
    goto(b + 16);

    // Inject into a slot freed by removal.
    do_reset(b);
    goto(b + 10);
    drive0(1'b1, D_MATCH);
    inj_req[0] = 1'b1;
    inj_data[63:0] = D_INJ;
    expect_at(b + 10, K_GNT0, 64'd1);
    expect_at(b + 11, K_TAP_VLD0, 64'd1);
    expect_at(b + 11, K_TAP_DATA0, D_MATCH);
    expect_at(b + 11, K_CNT_INJ0, cexp(64'd1));
    expect_at(b + 12, K_OUT_VLD0, 64'd1);
    expect_at(b + 12, K_OUT_DATA0, D_INJ);
    expect_at(b + 12, K_CNT_TAP0, cexp(64'd1));
    goto(b + 11);
    drive0(1'b0, 64'd0);
    inj_req[0] = 1'b0;
    expect_at(b + 11, K_GNT0, 64'd0);
    expect_at(b + 11, K_TAP_VLD0, 64'd1);
    goto(b + 16);

    // Starvation: full ring for 20 cycles, then one empty slot.
    do_reset(b);
    goto(b + 10);
    drive0(1'b1, D_PASS);
    inj_req[0] = 1'b1;
    inj_data[63:0] = D_INJ2;
    expect_at(b + 10, K_GNT0, 64'd0);
    expect_at(b + 11, K_STARVE0, 64'd0);
    expect_at(b + 24, K_STARVE0, 64'd0);
    expect_at(b + 24, K_GNT0, 64'd0);
    expect_at(b + 25, K_STARVE0, 64'd1);
    expect_at(b + 29, K_STARVE0, 64'd1);
    goto(b + 30);
    drive0(1'b0, 64'd0);
    expect_at(b + 30, K_GNT0, 64'd1);
    expect_at(b + 30, K_STARVE0, 64'd1);
    expect_at(b + 31, K_STARVE0, 64'd0);
    expect_at(b + 32, K_OUT_VLD0, 64'd1);
    expect_at(b + 32, K_OUT_DATA0, D_INJ2);
    goto(b + 31);
    inj_req[0] = 1'b0;
    goto(b + 36);

    // Mid-stream reset, then counter saturation and clear priority.
    do_reset(b);
    goto(b + 10);
    drive0(1'b1, D_PASS);
    expect_at(b + 19, K_OUT_VLD0, 64'd1);
    expect_at(b + 19, K_CNT_PASS0, cexp(64'd7));
    goto(b + 20);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_vld",  64'(ring_out_vld[0]), 64'd0);
    chk("midrst_out_data", ring_out_data[63:0], 64'd0);
    chk("midrst_tap_vld",  64'(tap_vld[0]), 64'd0);
    chk("midrst_cnt_pass", 64'(cnt_pass[15:0]), 64'd0);
    goto(b + 22);
    reset_n = 1'b1;
    expect_at(b + 23, K_OUT_VLD0, 64'd0);
    expect_at(b + 24, K_OUT_VLD0, 64'd1);
    expect_at(b + 24, K_CNT_PASS0, cexp(64'd0));
    expect_at(b + 25, K_CNT_PASS0, cexp(64'd1));
    expect_at(b + 24 + 70000, K_CNT_PASS0, cexp(64'hFFFF));
    c = b + 24 + 70005;
    goto(c);
    cnt_clr = 1'b1;
    expect_at(c + 1, K_CNT_PASS0, 64'd0);
    goto(c + 1);
    cnt_clr = 1'b0;
    expect_at(c + 2, K_CNT_PASS0, cexp(64'd1));
    goto(c + 5);
    clear_inputs();
    goto(c + 8);

    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
